// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction-SRAM request/response bus between fetch and SRAM
// Fetch side is the master: it raises the request, the SRAM acks and later returns data.
interface pc_fetch_if #(
   parameter int ADDR_W = 32
);
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_ack;
   logic              inst_rvalid;
   logic [31:0]       inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_ack,
      input  inst_rvalid,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_ack,
      output inst_rvalid,
      output inst_rdata
   );
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and instruction fetch with one branch delay slot
// Optional misaligned-target trap is enabled with macro PC_ALIGN_CHECK_EN.
module pc_fetch #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC00000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              cond_branch,
   input  logic              bgtz_sig,
   input  logic              zero_sig,
   input  logic [ADDR_W-1:0] jc_instaddress,
   pc_fetch_if.master        sram,
   output logic [31:0]       inst_out,
   output logic [ADDR_W-1:0] inst_pc_out,
   output logic              inst_valid_out,
   output logic [ADDR_W-1:0] next_instaddress,
   output logic              addr_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       out_inst_q, out_inst_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       skid_inst_q, skid_inst_d;
   logic              redirect_pend_q, redirect_pend_d;
   logic [ADDR_W-1:0] redirect_tgt_q, redirect_tgt_d;

   logic              consume;
   logic              taken;
   logic              pc_advance;
   logic [ADDR_W-1:0] npc_raw;
   logic [ADDR_W-1:0] npc;

`ifdef PC_ALIGN_CHECK_EN
   logic addr_err_q, addr_err_d;
   logic misaligned;
`endif

   always_comb begin
      consume = out_valid_q & ~stall;
      taken   = consume & (bgtz_sig | (cond_branch & zero_sig));

      // A latched redirect wins; otherwise a branch resolving this very cycle steers directly.
      if (redirect_pend_q)
         npc_raw = redirect_tgt_q;
      else if (taken)
         npc_raw = jc_instaddress;
      else
         npc_raw = pc_q + ADDR_W'(4);

`ifdef PC_ALIGN_CHECK_EN
      npc        = npc_raw;
      misaligned = |npc_raw[1:0];
`else
      npc        = npc_raw & ~ADDR_W'(3);
`endif
   end

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      out_inst_d      = out_inst_q;
      out_pc_d        = out_pc_q;
      out_valid_d     = out_valid_q;
      skid_inst_d     = skid_inst_q;
      redirect_pend_d = redirect_pend_q;
      redirect_tgt_d  = redirect_tgt_q;
      pc_advance      = 1'b0;
      sram.inst_req   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      addr_err_d      = addr_err_q;
`endif

      if (consume)
         out_valid_d = 1'b0;

      // The fetch in flight is the delay slot; remember the target for the fetch after it.
      if (taken && !redirect_pend_q) begin
         redirect_pend_d = 1'b1;
         redirect_tgt_d  = jc_instaddress;
      end

      case (state_q)
         S_IDLE: begin
`ifdef PC_ALIGN_CHECK_EN
            if (!addr_err_q)
               state_d = S_REQ;
`else
            state_d = S_REQ;
`endif
         end
         S_REQ: begin
            sram.inst_req = 1'b1;
            if (sram.inst_ack)
               state_d = S_WAIT;
         end
         S_WAIT: begin
            if (sram.inst_rvalid) begin
               if (!out_valid_q || consume) begin
                  out_inst_d  = sram.inst_rdata;
                  out_pc_d    = pc_q;
                  out_valid_d = 1'b1;
                  pc_advance  = 1'b1;
               end else begin
                  skid_inst_d = sram.inst_rdata;
                  state_d     = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // While parked here pc_q is still the PC of the buffered word.
            if (!stall) begin
               out_inst_d  = skid_inst_q;
               out_pc_d    = pc_q;
               out_valid_d = 1'b1;
               pc_advance  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pc_advance) begin
         redirect_pend_d = 1'b0;
         pc_d            = npc;
         state_d         = S_REQ;
`ifdef PC_ALIGN_CHECK_EN
         if (misaligned) begin
            pc_d       = pc_q;
            addr_err_d = 1'b1;
            state_d    = S_IDLE;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         pc_q            <= RESET_PC;
         out_inst_q      <= '0;
         out_pc_q        <= '0;
         out_valid_q     <= 1'b0;
         skid_inst_q     <= '0;
         redirect_pend_q <= 1'b0;
         redirect_tgt_q  <= '0;
`ifdef PC_ALIGN_CHECK_EN
         addr_err_q      <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         out_inst_q      <= out_inst_d;
         out_pc_q        <= out_pc_d;
         out_valid_q     <= out_valid_d;
         skid_inst_q     <= skid_inst_d;
         redirect_pend_q <= redirect_pend_d;
         redirect_tgt_q  <= redirect_tgt_d;
`ifdef PC_ALIGN_CHECK_EN
         addr_err_q      <= addr_err_d;
`endif
      end
   end

   assign sram.inst_addr   = pc_q;
   assign inst_out         = out_inst_q;
   assign inst_pc_out      = out_pc_q;
   assign inst_valid_out   = out_valid_q;
   assign next_instaddress = out_pc_q + ADDR_W'(4);

`ifdef PC_ALIGN_CHECK_EN
   assign addr_err = addr_err_q;
`else
   assign addr_err = 1'b0;
`endif

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- PC register and instruction-fetch stage of the MIPS core. It sits directly downstream of the branch-resolution block.
- Consumes bgtz_sig, zero_sig and jc_instaddress, and selects the next PC with one architectural delay slot.
- Drives the instruction-SRAM request/response handshake and presents the fetched instruction plus its PC to decode.
- Sources next_instaddress (PC+4 of the instruction in decode) back to the branch block.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  decode not accepting; hold output instruction.
- cond_branch  input  1  instruction in decode is beq/bne class.
- bgtz_sig  input  1  bgtz taken (from branch block).
- zero_sig  input  1  beq/bne condition met; qualified by cond_branch.
- jc_instaddress  input  32  branch/jump target.
- inst_req  output  1  SRAM request valid.
- inst_addr  output  32  request address.
- inst_ack  input  1  request accepted this cycle.
- inst_rvalid  input  1  read data valid (>=1 cycle after ack).
- inst_rdata  input  32  read data.
- inst_out  output  32  instruction to decode.
- inst_pc_out  output  32  PC of inst_out.
- inst_valid_out  output  1  inst_out valid.
- next_instaddress  output  32  inst_pc_out + 4, to branch block.
- addr_err  output  1  misaligned fetch (only with the optional feature).

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=IDLE.
  - inst_req=0, inst_valid_out=0, inst_out=0, inst_pc_out=0, redirect_pend=0, addr_err=0.
  - Reset mid-transaction abandons any outstanding read; an inst_rvalid arriving in the first 2 cycles after reset is discarded.
- taken = bgtz_sig | (cond_branch & zero_sig), sampled only when inst_valid_out=1 and stall=0.
- States:
  - IDLE: next cycle -> REQ.
  - REQ: inst_req=1, inst_addr=pc, held stable until inst_ack. On ack -> WAIT.
  - WAIT: inst_req=0. On inst_rvalid -> capture.
    - Capture writes {inst_rdata, pc} into the output register if it is empty or being consumed this cycle; then pc <= npc and state -> REQ.
    - Otherwise capture into a 1-entry skid buffer and go to HOLD.
  - HOLD: no request. When stall=0, move the buffer to the output register, update pc <= npc, state -> REQ.
- npc:
  - If redirect_pend, or taken in the same cycle: jc_instaddress (or the latched target).
  - Else pc+4.
  - Either way, the redirect clears.
- Delay slot:
  - The fetch in flight when taken is sampled is the delay slot and always completes and is delivered.
  - The redirect applies to the following fetch; the target is latched into redirect_tgt when not consumed the same cycle.
- Output register:
  - Updates only when empty or when inst_valid_out=1 and stall=0.
  - inst_valid_out drops to 0 when consumed with no new data.
- Throughput: max one instruction per 2 cycles (REQ+WAIT) with 1-cycle SRAM latency. No combinational path from inst_rdata to inst_out.
- Arithmetic: all PC adds are modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
- A second taken while redirect_pend=1 is ignored; it cannot legally occur because the delay slot is not a branch.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - If npc[1:0]!=0, do not issue the request.
  - Assert addr_err (sticky until rst), inst_valid_out=0 after the current output drains, state stays IDLE.
- Undefined:
  - npc[1:0] is forced to 2'b00.
  - addr_err is tied 0.

Test Plan:
- Reset, ack/rvalid 1 cycle later every time:
  - Expect addr sequence 0xBFC00000, 0xBFC00004, 0xBFC00008.
  - Expect inst_pc_out to match, and next_instaddress = inst_pc_out+4.
- Delay slot:
  - Stimulus: decode holds beq at 0xBFC00010, cond_branch=1, zero_sig=1, jc_instaddress=0xBFC00100.
  - Expect delay slot 0xBFC00014 delivered, then fetch 0xBFC00100.
- bgtz taken while the delay-slot fetch is still in WAIT for 3 cycles:
  - Expect the target latched.
  - Expect the fetch after 0x...14 to be the target.
  - Expect exactly one redirect.
- Stall:
  - Stimulus: stall=1 for 4 cycles with data returning.
  - Expect inst_out/inst_pc_out unchanged, one entry in the skid buffer, no new inst_req.
  - On release, expect in-order delivery with no loss or duplication.
- rst asserted in WAIT with rvalid the next cycle:
  - Expect data dropped, inst_valid_out=0, and restart at 0xBFC00000.
- With PC_ALIGN_CHECK_EN, jc_instaddress=0xBFC00102:
  - Expect addr_err=1 and no further inst_req.
- Without PC_ALIGN_CHECK_EN, jc_instaddress=0xBFC00102:
  - Expect fetch at 0xBFC00100.
